// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches one 16-bit instruction at a
// time over a req/ack handshake and presents it to the decoder. When execute
// signals completion, the next PC comes from the decoder's nextPCSel and
// instrData. At most one instruction is in flight at any time.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic [15:0]       instruction,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    input  logic              advance,
    input  logic [1:0]        nextPCSel,
    input  logic [15:0]       instrData,
    input  logic              halt,
    output logic              halted,
    output logic [15:0]       retired
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetchState;

    fetchState         state;
    fetchState         stateNext;
    logic              loadInstr;
    logic              retire;
    logic [ADDR_W-1:0] pcReg;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] pcIncrement;
    logic [ADDR_W-1:0] branchOffset;
    logic [15:0]       instrReg;
    logic [15:0]       retiredReg;

    // The branch offset is a sign-extended 16-bit value; fit it to the PC width.
    generate
        if (ADDR_W > 16) begin : gOffsetExtend
            assign branchOffset = {{(ADDR_W-16){instrData[15]}}, instrData};
        end else begin : gOffsetTrim
            assign branchOffset = instrData[ADDR_W-1:0];
        end
    endgenerate

    // Only 01 selects a branch; 00 and the reserved 1x codes fall through to pc+1.
    // The adder wraps naturally modulo 2^ADDR_W.
    always_comb begin
        pcIncrement = {{(ADDR_W-1){1'b0}}, 1'b1};
        if (nextPCSel == 2'b01) begin
            pcIncrement = branchOffset;
        end
        pcNext = pcReg + pcIncrement;
    end

    // State register; reset forces IDLE immediately so imem_req drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; acks, advances and halts are only honoured in the
    // state that expects them.
    always_comb begin
        stateNext = state;
        loadInstr = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                stateNext = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    loadInstr = 1'b1;
                    stateNext = VALID;
                end
            end
            VALID: begin
                if (advance) begin
                    retire    = 1'b1;
                    stateNext = halt ? HALTED : REQ;
                end
            end
            HALTED: begin
                stateNext = HALTED;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Datapath registers: instruction capture on ack, PC/retire update on advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcReg      <= RESET_PC;
            instrReg   <= 16'h0000;
            retiredReg <= 16'h0000;
        end else begin
            if (loadInstr) begin
                instrReg <= imem_rdata;
            end
            if (retire) begin
                pcReg      <= pcNext;
                retiredReg <= retiredReg + 16'h0001;
            end
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pcReg;
    assign pc          = pcReg;
    assign instruction = instrReg;
    assign instr_valid = (state == VALID);
    assign halted      = (state == HALTED);
    assign retired     = retiredReg;

endmodule
